// File: rtl/start_pause_pkg.sv
// ---------------------------------------------------------------------------
// start_pause_pkg
// Shared types and default constants for the start/pause button conditioner.
//   sp_state_e                 : press-tracking FSM states (2-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES    : 20 ms at 50 MHz
//   DEFAULT_LONG_PRESS_CYCLES  : 2 s at 50 MHz
//   DEFAULT_CNT_W              : counter width that holds both defaults
// ---------------------------------------------------------------------------
package start_pause_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } sp_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
  localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 100_000_000;
  localparam int unsigned DEFAULT_CNT_W             = 27;

endpackage

// File: rtl/start_pause_debouncer_debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
// Two-flop synchroniser, polarity normalisation and debounce counter for a
// raw pushbutton pin. Reusable for any panel button.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   button   : raw pin, asynchronous to clk
//   pressed  : debounced state, 1 = pressed
// ---------------------------------------------------------------------------
module debounce_filter
  import start_pause_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic pressed
);

  // Pin level when the button is not pressed; synchroniser resets to it so
  // that reset never looks like a press.
  localparam logic RELEASED_LEVEL = BUTTON_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             btn_s;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             pressed_q, pressed_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RELEASED_LEVEL;
      sync2_q <= RELEASED_LEVEL;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // XOR with the released level maps "pin at released level" to 0.
  assign btn_s = sync2_q ^ RELEASED_LEVEL;

  // The counter only advances on consecutive disagreeing cycles; any agreeing
  // cycle restarts the qualification window.
  always_comb begin
    deb_cnt_d = '0;
    pressed_d = pressed_q;
    if (btn_s != pressed_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        pressed_d = btn_s;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_q <= '0;
      pressed_q <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/start_pause_debouncer.sv
// ---------------------------------------------------------------------------
// start_pause_debouncer
// Turns the raw start/pause pushbutton into a clean run/pause level for the
// PIO in_port, plus one-cycle event strobes.
//   clk              : system clock
//   reset_n          : asynchronous active-low reset
//   button           : raw pushbutton pin (asynchronous)
//   clear            : synchronous force-to-pause request (level)
//   start_pause      : 1 = run, 0 = pause
//   press_pulse      : one-cycle strobe per accepted press
//   long_press_pulse : one-cycle strobe when a press is held long enough
//   pressed          : debounced button state, 1 = pressed
// ---------------------------------------------------------------------------
module start_pause_debouncer
  import start_pause_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter int unsigned CNT_W             = DEFAULT_CNT_W,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  input  logic clear,
  output logic start_pause,
  output logic press_pulse,
  output logic long_press_pulse,
  output logic pressed
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic             pressed_s;
  sp_state_e        state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             start_pause_q, start_pause_d;
  logic             press_pulse_q, press_pulse_d;
  logic             long_pulse_q, long_pulse_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .CNT_W            (CNT_W),
    .BUTTON_ACTIVE_LOW(BUTTON_ACTIVE_LOW)
  ) u_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .button (button),
    .pressed(pressed_s)
  );

  // State register together with the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      start_pause_q <= 1'b0;
      press_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      start_pause_q <= start_pause_d;
      press_pulse_q <= press_pulse_d;
      long_pulse_q  <= long_pulse_d;
    end
  end

  // Next-state and hold counter. On reaching the threshold the counter stays
  // at LONG_LAST, so it never wraps while the button stays down.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d    = HELD;
          hold_cnt_d = '0;
        end
      end
      HELD: begin
        if (!pressed_s) begin
          state_d = IDLE;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d = LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!pressed_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Priority on the run latch: clear > long press > toggle.
  always_comb begin
    press_pulse_d = (state_q == IDLE) && pressed_s;
    long_pulse_d  = (state_q == HELD) && pressed_s && (hold_cnt_q == LONG_LAST);
    start_pause_d = start_pause_q;
    if (press_pulse_d) start_pause_d = ~start_pause_q;
    if (long_pulse_d)  start_pause_d = 1'b0;
    if (clear)         start_pause_d = 1'b0;
  end

  assign start_pause      = start_pause_q;
  assign press_pulse      = press_pulse_q;
  assign long_press_pulse = long_pulse_q;
  assign pressed          = pressed_s;

endmodule
